axis_pkt_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing one packet FIFO write port among NumSrc AXI-stream sources.

---
 rtl/axis_arb_pkg.sv | 14 +
 rtl/axis_rr_pick.sv | 31 +++
 rtl/axis_pkt_arbiter.sv | 101 ++++++++++
 tb/tb_axis_pkt_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and default sizing for the packet-granular AXI-stream arbiter.
// ARB_PKT_CNT_EN (see axis_pkt_arbiter) adds per-source packet counters.
package axis_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam int unsigned DEF_NUM_SRC    = 4;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last',
// wrapping modulo NumSrc.
module axis_rr_pick
   import axis_arb_pkg::*;
#(
   parameter  int unsigned NumSrc  = DEF_NUM_SRC,
   localparam int unsigned IdWidth = $clog2(NumSrc)
) (
   input  logic [NumSrc-1:0]  req,
   input  logic [IdWidth-1:0] last,
   output logic [IdWidth-1:0] gnt_id,
   output logic               gnt_vld
);

   logic [IdWidth-1:0] idx;

   // Scan from the farthest offset down so the nearest requester after 'last' is written last and wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      for (int k = int'(NumSrc); k >= 1; k--) begin
         idx = IdWidth'((int'(last) + k) % int'(NumSrc));
         if (req[idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = idx;
         end
      end
   end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one FIFO write port from NumSrc AXI-stream sources.
// Optional macro ARB_PKT_CNT_EN adds the pkt_cnt port with per-source completed-packet counters.
module axis_pkt_arbiter
   import axis_arb_pkg::*;
#(
   parameter  int unsigned NumSrc    = DEF_NUM_SRC,
   parameter  int unsigned DataWidth = DEF_DATA_WIDTH,
   parameter  int unsigned CntWidth  = DEF_CNT_WIDTH,
   localparam int unsigned IdWidth   = $clog2(NumSrc)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NumSrc*DataWidth-1:0] s_tdata,
   input  logic [NumSrc-1:0]         s_tvalid,
   input  logic [NumSrc-1:0]         s_tlast,
   output logic [NumSrc-1:0]         s_tready,
   output logic                      m_req,
   output logic [DataWidth-1:0]      m_tdata,
   output logic                      m_tvalid,
   output logic                      m_tlast,
   input  logic                      m_tready,
   output logic [IdWidth-1:0]        grant_id,
`ifdef ARB_PKT_CNT_EN
   output logic [NumSrc*CntWidth-1:0] pkt_cnt,
`endif
   output logic                      busy
);

   arb_state_e         state;
   logic [IdWidth-1:0] last_grant;
   logic [IdWidth-1:0] pick_id;
   logic               pick_vld;
   logic               accept_last;

   axis_rr_pick #(.NumSrc(NumSrc)) u_pick (
      .req     (s_tvalid),
      .last    (last_grant),
      .gnt_id  (pick_id),
      .gnt_vld (pick_vld)
   );

   assign busy        = (state == BUSY);
   assign m_req       = busy;
   assign accept_last = m_tvalid & m_tready & m_tlast;

   // Zero-latency path from the granted source; everything is gated off while idle.
   always_comb begin
      m_tdata  = '0;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      s_tready = '0;
      for (int i = 0; i < int'(NumSrc); i++) begin
         if (busy && grant_id == IdWidth'(i)) begin
            m_tdata     = s_tdata[i*DataWidth +: DataWidth];
            m_tvalid    = s_tvalid[i];
            m_tlast     = s_tlast[i];
            s_tready[i] = m_tready;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= IdWidth'(NumSrc - 1);
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant_id <= pick_id;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (accept_last) begin
                  last_grant <= grant_id;
                  state      <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef ARB_PKT_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pkt_cnt <= '0;
      end else if (accept_last) begin
         for (int i = 0; i < int'(NumSrc); i++) begin
            if (grant_id == IdWidth'(i))
               pkt_cnt[i*CntWidth +: CntWidth] <= pkt_cnt[i*CntWidth +: CntWidth] + CntWidth'(1);
         end
      end
   end
`else
   logic unused_cnt_width;
   assign unused_cnt_width = (CntWidth != 0);
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Scoreboard bench for axis_pkt_arbiter: source queues drive beats, expected beats are
// queued in predicted grant order and compared as the FIFO side accepts them.
module tb_axis_pkt_arbiter;

   localparam int NS = 4;
   localparam int DW = 32;
   localparam int CW = 16;

   logic              clk;
   logic              reset_n;
   logic [NS*DW-1:0]  s_tdata;
   logic [NS-1:0]     s_tvalid;
   logic [NS-1:0]     s_tlast;
   logic [NS-1:0]     s_tready;
   logic              m_req;
   logic [DW-1:0]     m_tdata;
   logic              m_tvalid;
   logic              m_tlast;
   logic              m_tready;
   logic [1:0]        grant_id;
   logic              busy;
`ifdef ARB_PKT_CNT_EN
   logic [NS*CW-1:0]  pkt_cnt;
`endif

   int vectors;
   int miscompares;

   logic [32:0] src_q [NS][$];
   logic [34:0] exp_q [$];
   logic [NS-1:0] hold;

   axis_pkt_arbiter #(.NumSrc(NS), .DataWidth(DW), .CntWidth(CW)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tlast  (s_tlast),
      .s_tready (s_tready),
      .m_req    (m_req),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tlast  (m_tlast),
      .m_tready (m_tready),
      .grant_id (grant_id),
`ifdef ARB_PKT_CNT_EN
      .pkt_cnt  (pkt_cnt),
`endif
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // FIFO-side monitor: every accepted beat must be the next expected {grant, last, data}.
   always @(negedge clk) begin
      logic [34:0] e;
      if (reset_n && m_tvalid && m_tready) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_beat: got grant=%0d last=%0b data=%08h, scoreboard empty",
                     grant_id, m_tlast, m_tdata);
         end else begin
            e = exp_q.pop_front();
            if ({grant_id, m_tlast, m_tdata} !== e) begin
               miscompares++;
               $display("FAIL beat: got grant=%0d last=%0b data=%08h want grant=%0d last=%0b data=%08h",
                        grant_id, m_tlast, m_tdata, e[34:33], e[32], e[31:0]);
            end
         end
      end
   end

   function automatic logic [31:0] beat_data(int s, int p, int b);
      return 32'hA000_0000 | (32'(s) << 16) | (32'(p) << 8) | 32'(b);
   endfunction

   task automatic add_pkt(int s, int p, int len);
      logic [31:0] d;
      logic        l;
      for (int b = 0; b < len; b++) begin
         d = beat_data(s, p, b);
         l = (b == len - 1);
         src_q[s].push_back({l, d});
         exp_q.push_back({2'(s), l, d});
      end
   endtask

   task automatic drive_sources();
      for (int i = 0; i < NS; i++) begin
         if (src_q[i].size() > 0 && !hold[i]) begin
            s_tvalid[i]          = 1'b1;
            s_tlast[i]           = src_q[i][0][32];
            s_tdata[i*DW +: DW]  = src_q[i][0][31:0];
         end else begin
            s_tvalid[i]          = 1'b0;
            s_tlast[i]           = 1'b0;
            s_tdata[i*DW +: DW]  = '0;
         end
      end
   endtask

   task automatic start();
      drive_sources();
      #1;
   endtask

   // One clock: note which sources handshake, then advance those source queues after the edge.
   task automatic step();
      logic [NS-1:0] acc;
      @(negedge clk);
      acc = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++)
         if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      drive_sources();
      #1;
   endtask

   task automatic reset_dut();
      reset_n  = 1'b0;
      m_tready = 1'b1;
      hold     = '0;
      exp_q.delete();
      for (int i = 0; i < NS; i++) src_q[i].delete();
      drive_sources();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
   endtask

   task automatic drain(string name, int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         step();
         n++;
      end
      vectors++;
      if (exp_q.size() != 0 || busy) begin
         miscompares++;
         $display("FAIL %s_drain: got %0d beats outstanding busy=%0b after %0d cycles, want 0 and idle",
                  name, exp_q.size(), busy, budget);
      end
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      m_tready = 1'b1;
      s_tvalid = '1;
      s_tlast  = '1;
      s_tdata  = '1;
      #1;
      vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
      vectors++; if (m_req !== 1'b0)    begin miscompares++; $display("FAIL rst_req: got %b want 0", m_req); end
      vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
      vectors++; if (m_tlast !== 1'b0)  begin miscompares++; $display("FAIL rst_tlast: got %b want 0", m_tlast); end
      vectors++; if (s_tready !== 4'b0) begin miscompares++; $display("FAIL rst_tready: got %b want 0000", s_tready); end
      vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
`ifdef ARB_PKT_CNT_EN
      vectors++; if (pkt_cnt !== '0) begin miscompares++; $display("FAIL rst_pkt_cnt: got %h want 0", pkt_cnt); end
`endif
      reset_dut();
      step();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_no_req: got busy=%b want 0", busy); end
   endtask

   task automatic test_single_src();
      reset_dut();
      add_pkt(0, 0, 3);
      start();
      vectors++; if (busy !== 1'b0 || m_tvalid !== 1'b0)
         begin miscompares++; $display("FAIL single_bubble: got busy=%b tvalid=%b want 0 0", busy, m_tvalid); end
      step();
      vectors++; if (busy !== 1'b1 || m_req !== 1'b1 || grant_id !== 2'd0)
         begin miscompares++; $display("FAIL single_grant: got busy=%b req=%b grant=%0d want 1 1 0", busy, m_req, grant_id); end
      for (int b = 0; b < 2; b++) begin
         step();
         vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_b%0d: got %b want 1", b, busy); end
      end
      step();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_done: got busy=%b want 0", busy); end
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL single_beats: got %0d left want 0", exp_q.size()); end
`ifdef ARB_PKT_CNT_EN
      vectors++; if (pkt_cnt[0 +: CW] !== 16'd1) begin miscompares++; $display("FAIL single_cnt: got %0d want 1", pkt_cnt[0 +: CW]); end
`endif
   endtask

   task automatic test_round_robin();
      reset_dut();
      add_pkt(0, 0, 2);
      add_pkt(1, 0, 2);
      add_pkt(2, 0, 2);
      add_pkt(3, 0, 2);
      add_pkt(0, 1, 2);
      start();
      drain("rr", 100);
`ifdef ARB_PKT_CNT_EN
      vectors++; if (pkt_cnt !== {16'd1, 16'd1, 16'd1, 16'd2})
         begin miscompares++; $display("FAIL rr_cnt: got %h want 0001000100010002", pkt_cnt); end
`endif
   endtask

   task automatic test_backpressure();
      reset_dut();
      add_pkt(2, 0, 4);
      start();
      step();
      vectors++; if (grant_id !== 2'd2) begin miscompares++; $display("FAIL bp_grant: got %0d want 2", grant_id); end
      step();
      m_tready = 1'b0;
      #1;
      for (int c = 0; c < 5; c++) begin
         vectors++; if (m_tvalid !== 1'b1 || s_tready[2] !== 1'b0 || m_tdata !== beat_data(2, 0, 1))
            begin miscompares++; $display("FAIL bp_hold_c%0d: got tvalid=%b tready=%b data=%08h want 1 0 %08h",
                                          c, m_tvalid, s_tready[2], m_tdata, beat_data(2, 0, 1)); end
         step();
      end
      m_tready = 1'b1;
      #1;
      drain("bp", 50);
   endtask

   task automatic test_drop_valid();
      reset_dut();
      add_pkt(1, 0, 4);
      add_pkt(3, 0, 2);
      start();
      step();
      vectors++; if (grant_id !== 2'd1) begin miscompares++; $display("FAIL drop_grant: got %0d want 1", grant_id); end
      step();
      hold[1] = 1'b1;
      start();
      for (int c = 0; c < 4; c++) begin
         vectors++; if (m_tvalid !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd1 || s_tready[3] !== 1'b0)
            begin miscompares++; $display("FAIL drop_hold_c%0d: got tvalid=%b busy=%b grant=%0d tready3=%b want 0 1 1 0",
                                          c, m_tvalid, busy, grant_id, s_tready[3]); end
         step();
      end
      hold[1] = 1'b0;
      start();
      drain("drop", 50);
   endtask

   task automatic test_back_to_back();
      int n;
      reset_dut();
      for (int p = 0; p < 4; p++) add_pkt(3, p, 1);
      start();
      n = 0;
      while ((src_q[3].size() > 0 || busy) && n < 20) begin
         step();
         n++;
         vectors++; if (grant_id !== 2'd3 || busy !== n[0])
            begin miscompares++; $display("FAIL b2b_cycle%0d: got grant=%0d busy=%b want 3 %b", n, grant_id, busy, n[0]); end
      end
      vectors++; if (n != 8) begin miscompares++; $display("FAIL b2b_cycles: got %0d want 8", n); end
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_beats: got %0d left want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      reset_dut();
      add_pkt(0, 0, 3);
      add_pkt(1, 0, 1);
      start();
      step();
      step();
      reset_n = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0 || m_req !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0)
         begin miscompares++; $display("FAIL midrst_ctl: got busy=%b req=%b tvalid=%b tlast=%b want 0 0 0 0",
                                       busy, m_req, m_tvalid, m_tlast); end
      vectors++; if (s_tready !== 4'b0 || grant_id !== 2'd0)
         begin miscompares++; $display("FAIL midrst_grant: got tready=%b grant=%0d want 0000 0", s_tready, grant_id); end
      reset_dut();
      add_pkt(0, 1, 3);
      add_pkt(1, 0, 1);
      start();
      step();
      vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL midrst_regrant: got %0d want 0", grant_id); end
      drain("midrst", 50);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      hold        = '0;
      reset_n     = 1'b0;
      m_tready    = 1'b1;
      s_tvalid    = '0;
      s_tlast     = '0;
      s_tdata     = '0;
      test_reset();
      test_single_src();
      test_round_robin();
      test_backpressure();
      test_drop_valid();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
